alu_seq_divider: RTL and testbench

//  Iterative 32-bit restoring divider for the MIPS ALU (DIV/DIVU); the sequential

---
 rtl/alu_seq_divider.sv | 153 +++++++++++++++
 tb/tb_alu_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, quotient/remainder registered on DONE.
// Optional signed (MIPS DIV) support is compiled in with `define ALU_DIV_SIGNED_EN.
module alu_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  // Operand magnitudes and result sign flags captured on the accepted start.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef ALU_DIV_SIGNED_EN
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One restoring step: trial subtract of the divisor from the shifted partial remainder.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic             unused_trial_bit;
  assign shifted          = {rem_q, dvd_q[WIDTH-1]};
  assign trial            = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_ok         = ~trial[WIDTH+1];
  assign unused_trial_bit = trial[WIDTH];

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          dvd_d      = a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          count_d    = '0;
          div_zero_d = (b == '0);
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        if (trial_ok) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        // Divide-by-zero keeps the all-ones quotient; the remainder sign fix restores a.
        quotient_d  = (q_neg_q && !div_zero_q) ? -dvd_q : dvd_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: vector table plus scoreboard, with hand sequences
// for mid-RUN start, mid-operation reset and (when ALU_DIV_SIGNED_EN is defined) signed cases.
module tb_alu_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
`ifdef ALU_DIV_SIGNED_EN
  logic        is_signed;
`endif
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  always #5 clk = ~clk;

  alu_seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef ALU_DIV_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_q   = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] va, input logic [31:0] vb,
                              input logic sg, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    vec_t v;
    v.name = nm; v.a = va; v.b = vb; v.sg = sg; v.q = q; v.r = r; v.dz = dz;
    return v;
  endfunction

  // Runs one operation; glitch_at >= 0 re-pulses start with different operands during RUN.
  task automatic run_op(input vec_t v, input int glitch_at);
    exp_t e;
    int   k;
    int   busy_cnt;
    @(negedge clk);
    a = v.a;
    b = v.b;
`ifdef ALU_DIV_SIGNED_EN
    is_signed = v.sg;
`endif
    start = 1'b1;
    sb.push_back('{q: v.q, r: v.r, dz: v.dz});
    k = 0;
    busy_cnt = 0;
    while (k < 60) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      if (k == 2) check({v.name, "/hold_q"}, quotient, last_q);
      if (k == glitch_at) begin
        start = 1'b1;
        a = ~v.a;
        b = v.b + 32'd3;
      end else begin
        start = 1'b0;
      end
      k++;
    end
    start = 1'b0;
    if (k >= 60) begin
      check({v.name, "/timeout"}, 32'(k), 32'd33);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({v.name, "/latency"}, 32'(k), 32'd33);
      check({v.name, "/busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({v.name, "/busy_at_done"}, 32'(busy), 32'd0);
      check({v.name, "/q"}, quotient, e.q);
      check({v.name, "/r"}, remainder, e.r);
      check({v.name, "/div_zero"}, 32'(div_zero), 32'(e.dz));
      last_q = e.q;
      @(negedge clk);
      check({v.name, "/done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        seen_done;

    vecs.push_back(mk("div100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,    1'b0));
    vecs.push_back(mk("max_by_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,    1'b0));
    vecs.push_back(mk("5_by_9",     32'd5,          32'd9,          1'b0, 32'd0,          32'd5,    1'b0));
    vecs.push_back(mk("by_zero",    32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234, 1'b1));
    vecs.push_back(mk("max_by_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,    1'b0));
    vecs.push_back(mk("msb_by_3",   32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,    1'b0));
    vecs.push_back(mk("u_neg7_2",   32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,    1'b0));
`ifdef ALU_DIV_SIGNED_EN
    vecs.push_back(mk("s_neg7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk("s_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,    1'b0));
    vecs.push_back(mk("s_7_neg2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,    1'b0));
    vecs.push_back(mk("s_neg_by0",  32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9, 1'b1));
`endif

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef ALU_DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/q", quotient, 32'd0);
    check("reset/r", remainder, 32'd0);
    check("reset/div_zero", 32'(div_zero), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], -1);

    // Start re-pulsed mid-RUN with different operands must be ignored.
    run_op(mk("mid_start", 32'd1000, 32'd13, 1'b0, 32'd76, 32'd12, 1'b0), 10);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h00FF_FFFF);
      run_op(mk($sformatf("rand%0d", i), ra, rb, 1'b0, ra / rb, ra % rb, 1'b0), -1);
    end

    // Reset at iteration 10 aborts the operation with no done pulse.
    run_op(vecs[3], -1);
    @(negedge clk);
    a = 32'd5000;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/done", 32'(done), 32'd0);
    check("abort/q", quotient, 32'd0);
    check("abort/r", remainder, 32'd0);
    check("abort/div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_q = '0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort/no_done", 32'(seen_done), 32'd0);
    run_op(vecs[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
